// File: rtl/m72_pic.sv
// 8259A/uPD71059-style interrupt controller for the M72 main CPU: fully-nested priority over
// eight request lines, an ICW/OCW register file, and a vector driven onto the read path during acknowledge.
module m72_pic #(
  parameter logic [7:0] DEFAULT_BASE = 8'h20
) (
  input  logic        CLK_32M,
  input  logic        reset_n,
  input  logic        CS,
  input  logic        A0,
  input  logic        IOWR,
  input  logic        IORD,
  input  logic [7:0]  DIN,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic [7:0]  IR,
  output logic        INT_RQ,
  input  logic        INT_ACK
);

  typedef enum logic [1:0] {READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} init_state_t;

  init_state_t state_q, state_d;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, vec_q, vec_d;
  logic [7:0] ir_q;
  logic [4:0] base_q, base_d;
  logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d, aeoi_q, aeoi_d;
  logic       rd_isr_q, rd_isr_d;
  logic       wr_q, ack_q, int_rq_q;

  logic       wr_stb, ack_rise, cand_vld, icw1;
  logic [7:0] ir_rise, cand, isr_low, ack_clr, eoi_clr;
  logic [7:0] ack_vec;

  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign wr_stb   = CS & IOWR & ~wr_q;
  assign ack_rise = INT_ACK & ~ack_q;
  assign ir_rise  = IR & ~ir_q;
  assign cand     = lowest_bit(irr_q & ~imr_q);
  assign isr_low  = lowest_bit(isr_q);
  // One-hot masks compare the same way as their indices, so "index below the lowest ISR bit" is a magnitude test.
  assign cand_vld = (cand != 8'h00) && ((isr_q == 8'h00) || (cand < isr_low));
  assign ack_vec  = {base_q, cand_vld ? encode(cand) : 3'd7};
  assign ack_clr  = (ack_rise && cand_vld) ? cand : 8'h00;
  assign INT_RQ   = int_rq_q;

  always_comb begin
    state_d  = state_q;
    imr_d    = imr_q;
    base_d   = base_q;
    ltim_d   = ltim_q;
    sngl_d   = sngl_q;
    ic4_d    = ic4_q;
    aeoi_d   = aeoi_q;
    rd_isr_d = rd_isr_q;
    vec_d    = ack_rise ? ack_vec : vec_q;
    icw1     = 1'b0;
    eoi_clr  = 8'h00;

    if (wr_stb) begin
      if (!A0 && DIN[4]) begin
        icw1     = 1'b1;
        imr_d    = 8'h00;
        rd_isr_d = 1'b0;
        ltim_d   = DIN[3];
        sngl_d   = DIN[1];
        ic4_d    = DIN[0];
        state_d  = WAIT_ICW2;
      end else begin
        unique case (state_q)
          WAIT_ICW2: if (A0) begin
            base_d  = DIN[7:3];
            state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: if (A0) state_d = ic4_q ? WAIT_ICW4 : READY;
          WAIT_ICW4: if (A0) begin
            aeoi_d  = DIN[1];
            state_d = READY;
          end
          READY: begin
            if (A0) begin
              imr_d = DIN;
            end else if (DIN[4:3] == 2'b00) begin
              if (DIN[7:5] == 3'b001) eoi_clr = isr_low;
              else if (DIN[7:5] == 3'b011) eoi_clr = 8'h01 << DIN[2:0];
            end else if (DIN[1]) begin
              rd_isr_d = DIN[0];
            end
          end
          default: state_d = READY;
        endcase
      end
    end

    // A new edge on a bit being acknowledged wins over the acknowledge clear.
    if (icw1)        irr_d = 8'h00;
    else if (ltim_q) irr_d = IR & ~ack_clr;
    else             irr_d = (irr_q & ~ack_clr) | ir_rise;

    if (icw1) isr_d = 8'h00;
    else      isr_d = (isr_q & ~eoi_clr) | (aeoi_q ? 8'h00 : ack_clr);
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= READY;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      imr_q    <= 8'hFF;
      vec_q    <= 8'h00;
      ir_q     <= 8'h00;
      base_q   <= DEFAULT_BASE[7:3];
      ltim_q   <= 1'b0;
      sngl_q   <= 1'b0;
      ic4_q    <= 1'b0;
      aeoi_q   <= 1'b0;
      rd_isr_q <= 1'b0;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
      int_rq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      vec_q    <= vec_d;
      ir_q     <= IR;
      base_q   <= base_d;
      ltim_q   <= ltim_d;
      sngl_q   <= sngl_d;
      ic4_q    <= ic4_d;
      aeoi_q   <= aeoi_d;
      rd_isr_q <= rd_isr_d;
      wr_q     <= CS & IOWR;
      ack_q    <= INT_ACK;
      int_rq_q <= cand_vld;
    end
  end

  // Acknowledge owns the read path; the edge cycle shows the vector before it is latched.
  always_comb begin
    DOUT       = 16'h0000;
    DOUT_VALID = 1'b0;
    if (INT_ACK) begin
      DOUT_VALID = 1'b1;
      DOUT       = {8'h00, ack_rise ? ack_vec : vec_q};
    end else if (CS && IORD) begin
      DOUT_VALID = 1'b1;
      DOUT       = {8'h00, A0 ? imr_q : (rd_isr_q ? isr_q : irr_q)};
    end
  end

endmodule

// File: tb/tb_m72_pic.sv
// Bench for m72_pic: directed init/priority/EOI/AEOI/reset sequences, then a randomized phase
// checked against a bit-per-line behavioural model of IRR/ISR/IMR.
`timescale 1ns/1ps
module tb_m72_pic;
  logic        CLK_32M = 1'b0;
  logic        reset_n = 1'b0;
  logic        CS = 1'b0, A0 = 1'b0, IOWR = 1'b0, IORD = 1'b0, INT_ACK = 1'b0;
  logic [7:0]  DIN = 8'h00, IR = 8'h00;
  logic [15:0] DOUT;
  logic        DOUT_VALID, INT_RQ;

  int n_cmp = 0, n_err = 0;

  bit [7:0] m_irr, m_isr, m_imr;
  bit [4:0] m_base;
  bit       m_aeoi;

  m72_pic dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .CS(CS), .A0(A0), .IOWR(IOWR), .IORD(IORD),
    .DIN(DIN), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .IR(IR), .INT_RQ(INT_RQ), .INT_ACK(INT_ACK)
  );

  always #16 CLK_32M = ~CLK_32M;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic wr_h(input logic a0, input logic [7:0] d, input int hold);
    CS = 1'b1; IOWR = 1'b1; A0 = a0; DIN = d;
    repeat (hold) tick();
    CS = 1'b0; IOWR = 1'b0;
    tick();
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    wr_h(a0, d, $urandom_range(1, 3));
  endtask

  task automatic rd(input logic a0, output logic [7:0] v);
    CS = 1'b1; IORD = 1'b1; A0 = a0;
    #2;
    chk("rd_valid", {15'h0, DOUT_VALID}, 16'h0001);
    chk("rd_upper", {8'h00, DOUT[15:8]}, 16'h0000);
    v = DOUT[7:0];
    CS = 1'b0; IORD = 1'b0;
    #1;
  endtask

  task automatic rd_reg(input logic sel_isr, output logic [7:0] v);
    wr(1'b0, sel_isr ? 8'h0B : 8'h0A);
    rd(1'b0, v);
  endtask

  task automatic pulse(input logic [7:0] m);
    IR = m; tick();
    IR = 8'h00; tick();
    m_irr |= m;
  endtask

  task automatic ack(input logic with_rd, output logic [7:0] v);
    INT_ACK = 1'b1;
    if (with_rd) begin CS = 1'b1; IORD = 1'b1; A0 = 1'b1; end
    #2;
    chk("ack_valid", {15'h0, DOUT_VALID}, 16'h0001);
    v = DOUT[7:0];
    chk("ack_upper", {8'h00, DOUT[15:8]}, 16'h0000);
    tick();
    chk("ack_held", DOUT, {8'h00, v});
    INT_ACK = 1'b0; CS = 1'b0; IORD = 1'b0;
    tick(); tick();
  endtask

  // Highest-priority serviceable line, or -1; nested rule: must beat every in-service line.
  function automatic int m_cand();
    int c = -1;
    int s = 8;
    for (int i = 7; i >= 0; i--) begin
      if (m_irr[i] && !m_imr[i]) c = i;
      if (m_isr[i]) s = i;
    end
    return (c >= 0 && c < s) ? c : -1;
  endfunction

  task automatic m_ack(output logic [7:0] ev);
    int c = m_cand();
    if (c < 0) ev = {m_base, 3'd7};
    else begin
      ev = {m_base, 3'(c)};
      m_irr[c] = 1'b0;
      if (!m_aeoi) m_isr[c] = 1'b1;
    end
  endtask

  task automatic m_eoi_ns();
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) begin m_isr[i] = 1'b0; break; end
    end
  endtask

  task automatic init(input logic [7:0] icw2, input logic [7:0] icw4);
    wr(1'b0, 8'h13); wr(1'b1, icw2); wr(1'b1, icw4);
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00;
    m_base = icw2[7:3]; m_aeoi = icw4[1];
  endtask

  initial begin
    logic [7:0] v, m, ev;
    int n;

    #40;
    chk("rst_int_rq", {15'h0, INT_RQ}, 16'h0000);
    chk("rst_dout", DOUT, 16'h0000);
    chk("rst_dout_valid", {15'h0, DOUT_VALID}, 16'h0000);
    reset_n = 1'b1;
    tick();
    rd(1'b1, v); chk("rst_imr", {8'h00, v}, 16'h00FF);
    rd(1'b0, v); chk("rst_irr", {8'h00, v}, 16'h0000);

    // Basic init and single request
    init(8'h20, 8'h01);
    wr(1'b1, 8'hFA);
    pulse(8'h01);
    chk("ir0_rq", {15'h0, INT_RQ}, 16'h0001);
    ack(1'b0, v); chk("ir0_vec", {8'h00, v}, 16'h0020);
    rd_reg(1'b1, v); chk("ir0_isr", {8'h00, v}, 16'h0001);
    chk("ir0_rq_drop", {15'h0, INT_RQ}, 16'h0000);

    // Lower priority blocked while IR0 in service
    pulse(8'h04);
    chk("ir2_blocked", {15'h0, INT_RQ}, 16'h0000);
    wr(1'b0, 8'h20);
    rd(1'b0, v); chk("eoi_isr", {8'h00, v}, 16'h0000);
    chk("ir2_rq", {15'h0, INT_RQ}, 16'h0001);
    ack(1'b1, v); chk("ir2_vec_rdmux", {8'h00, v}, 16'h0022);
    wr(1'b0, 8'h20);

    // Simultaneous IR0 and IR2
    pulse(8'h05);
    ack(1'b0, v); chk("dual_first", {8'h00, v}, 16'h0020);
    wr(1'b0, 8'h20);
    ack(1'b0, v); chk("dual_second", {8'h00, v}, 16'h0022);
    wr(1'b0, 8'h20);
    rd(1'b0, v); chk("dual_isr_clear", {8'h00, v}, 16'h0000);

    // Masked request and spurious acknowledge
    wr(1'b1, 8'hFF);
    pulse(8'h01);
    chk("masked_rq", {15'h0, INT_RQ}, 16'h0000);
    rd_reg(1'b0, v); chk("masked_irr", {8'h00, v}, 16'h0001);
    ack(1'b0, v); chk("spurious_vec", {8'h00, v}, 16'h0027);
    rd_reg(1'b1, v); chk("spurious_isr", {8'h00, v}, 16'h0000);
    rd_reg(1'b0, v); chk("spurious_irr", {8'h00, v}, 16'h0001);

    // Nested service and a long non-specific EOI strobe acting once
    init(8'h20, 8'h01);
    wr(1'b1, 8'h00);
    pulse(8'h04);
    ack(1'b0, v); chk("nest_low_vec", {8'h00, v}, 16'h0022);
    pulse(8'h01);
    chk("nest_preempt_rq", {15'h0, INT_RQ}, 16'h0001);
    ack(1'b0, v); chk("nest_high_vec", {8'h00, v}, 16'h0020);
    rd_reg(1'b1, v); chk("nest_isr", {8'h00, v}, 16'h0005);
    wr_h(1'b0, 8'h20, 3);
    rd(1'b0, v); chk("nest_eoi_once", {8'h00, v}, 16'h0004);
    wr(1'b0, 8'h62);
    rd(1'b0, v); chk("nest_specific_eoi", {8'h00, v}, 16'h0000);

    // Randomized phase against the model
    m = 8'($urandom);
    init({m[7:3], 3'b000}, $urandom_range(0, 1) ? 8'h03 : 8'h01);
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          m = $urandom_range(0, 1) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
          pulse(m);
        end
        2, 3: begin
          m_ack(ev);
          ack(1'($urandom_range(0, 1)), v);
          chk("rnd_vec", {8'h00, v}, {8'h00, ev});
        end
        4: begin
          wr(1'b0, 8'h20);
          m_eoi_ns();
        end
        5: begin
          n = $urandom_range(0, 7);
          wr(1'b0, 8'h60 | 8'(n));
          m_isr[n] = 1'b0;
        end
        default: begin
          m = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
          wr(1'b1, m);
          m_imr = m;
        end
      endcase
      chk("rnd_rq", {15'h0, INT_RQ}, {15'h0, m_cand() >= 0});
      if (k % 10 == 9) begin
        rd_reg(1'b0, v); chk("rnd_irr", {8'h00, v}, {8'h00, m_irr});
        rd_reg(1'b1, v); chk("rnd_isr", {8'h00, v}, {8'h00, m_isr});
        rd(1'b1, v);     chk("rnd_imr", {8'h00, v}, {8'h00, m_imr});
      end
    end

    // Automatic EOI
    init(8'h20, 8'h03);
    wr(1'b1, 8'hFA);
    pulse(8'h01);
    ack(1'b0, v); chk("aeoi_vec", {8'h00, v}, 16'h0020);
    rd_reg(1'b1, v); chk("aeoi_isr", {8'h00, v}, 16'h0000);
    chk("aeoi_rq_drop", {15'h0, INT_RQ}, 16'h0000);
    pulse(8'h01);
    chk("aeoi_rq_again", {15'h0, INT_RQ}, 16'h0001);

    // Reset in the middle of initialisation
    wr(1'b0, 8'h13);
    reset_n = 1'b0;
    #5;
    chk("midrst_rq", {15'h0, INT_RQ}, 16'h0000);
    reset_n = 1'b1;
    tick();
    rd(1'b1, v); chk("midrst_imr", {8'h00, v}, 16'h00FF);
    wr(1'b1, 8'h00);
    rd(1'b1, v); chk("midrst_ocw1", {8'h00, v}, 16'h0000);
    pulse(8'h01);
    chk("midrst_rq_ir0", {15'h0, INT_RQ}, 16'h0001);
    ack(1'b0, v); chk("midrst_default_base", {8'h00, v}, 16'h0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
